// File: rtl/ne_ffp_norm_pack.sv
// ne_ffp_norm_pack: converts the unnormalized FFP adder-tree sum into a packed
// binary32 word (RNE to fp32 or tf32 precision) or passes integers through,
// and counts exponent overflow/underflow events.
//
// Handshake: a word moves on an edge where valid & ready are both high.
// adv = ~out_valid | out_ready. Every register stage (S1, S2, S3, output)
// advances together when adv is high and holds, bubbles included, when it is
// low. in_ready = adv. Once out_valid is high, out_data is stable until the
// edge on which out_ready is sampled high.
module ne_ffp_norm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [40:0]      in_data,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt
);

    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // S1 registers: captured word and its mode
    logic        s1_valid;
    logic [2:0]  s1_mode;
    logic [40:0] s1_data;

    // S2 registers: magnitude, leading-one position, unbiased exponent
    logic        s2_valid, s2_int, s2_tf32, s2_sign, s2_s;
    kind_t       s2_kind;
    logic [26:0] s2_mag;
    logic [4:0]  s2_p;
    logic [11:0] s2_exp;
    logic [31:0] s2_iword;

    // S3 registers: rounded fraction and final exponent
    logic        s3_valid, s3_int, s3_sign, s3_s;
    kind_t       s3_kind;
    logic [22:0] s3_frac;
    logic [11:0] s3_exp;
    logic [31:0] s3_iword;

    logic out_ovf, out_unf;

    // S1 combinational: classify, take magnitude (-2^26 maps to 2^26), find leading one
    logic [26:0] s1_m, s1_mag;
    logic [9:0]  s1_e;
    logic [4:0]  s1_p;
    logic [11:0] s1_exp;
    kind_t       s1_kind;
    always_comb begin
        s1_m    = s1_data[26:0];
        s1_e    = s1_data[36:27];
        s1_mag  = s1_m[26] ? (~s1_m + 27'd1) : s1_m;
        s1_p    = '0;
        for (int i = 0; i < 27; i++) begin
            if (s1_mag[i]) s1_p = 5'(i);
        end
        s1_exp  = {{2{s1_e[9]}}, s1_e} - 12'd25 + {7'd0, s1_p};
        if (s1_data[40])                     s1_kind = K_NAN;
        else if (s1_data[39])                s1_kind = K_INF;
        else if (s1_data[38] || s1_m == '0)  s1_kind = K_ZERO;
        else                                 s1_kind = K_NORM;
    end

    // S2 combinational: normalize so the leading one sits at bit 26, then RNE
    logic [25:0] s2_nrm;
    logic        inc32, inc16;
    logic [23:0] rnd32;
    logic [10:0] rnd16;
    logic [22:0] s2_frac;
    logic        s2_carry;
    always_comb begin
        s2_nrm   = 26'(s2_mag << (5'd26 - s2_p));
        inc32    = s2_nrm[2] & ((|s2_nrm[1:0]) | s2_nrm[3]);
        inc16    = s2_nrm[15] & ((|s2_nrm[14:0]) | s2_nrm[16]);
        rnd32    = {1'b0, s2_nrm[25:3]} + {23'd0, inc32};
        rnd16    = {1'b0, s2_nrm[25:16]} + {10'd0, inc16};
        s2_frac  = s2_tf32 ? {rnd16[9:0], 13'd0} : rnd32[22:0];
        s2_carry = s2_tf32 ? rnd16[10] : rnd32[23];
    end

    // S3 combinational: bias, range check and pack
    logic [11:0] biased;
    logic [31:0] pack_word;
    logic        pack_ovf, pack_unf;
    always_comb begin
        biased    = s3_exp + 12'd127;
        pack_word = '0;
        pack_ovf  = 1'b0;
        pack_unf  = 1'b0;
        if (s3_int) begin
            pack_word = s3_iword;
        end else begin
            case (s3_kind)
                K_NAN:  pack_word = 32'h7FC0_0000;
                K_INF:  pack_word = {s3_s, 8'hFF, 23'd0};
                K_ZERO: pack_word = {s3_s, 31'd0};
                default: begin
                    if ($signed(biased) >= 12'sd255) begin
                        pack_word = {s3_sign, 8'hFF, 23'd0};
                        pack_ovf  = 1'b1;
                    end else if ($signed(biased) <= 12'sd0) begin
                        pack_word = {s3_sign, 31'd0};
                        pack_unf  = 1'b1;
                    end else begin
                        pack_word = {s3_sign, biased[7:0], s3_frac};
                    end
                end
            endcase
        end
    end

    // Valid bits and output word: reset clears them, otherwise shift on adv
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            out_data  <= pack_word;
            out_ovf   <= s3_valid & pack_ovf;
            out_unf   <= s3_valid & pack_unf;
        end
    end

    // Datapath registers: no reset needed, qualified by the valid bits
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_mode  <= in_mode;
            s1_data  <= in_data;
            s2_int   <= (s1_mode == 3'b001);
            s2_tf32  <= (s1_mode == 3'b100);
            s2_sign  <= s1_m[26];
            s2_s     <= s1_data[37];
            s2_kind  <= s1_kind;
            s2_mag   <= s1_mag;
            s2_p     <= s1_p;
            s2_exp   <= s1_exp;
            s2_iword <= {{9{s1_data[22]}}, s1_data[22:0]};
            s3_int   <= s2_int;
            s3_sign  <= s2_sign;
            s3_s     <= s2_s;
            s3_kind  <= s2_kind;
            s3_frac  <= s2_frac;
            s3_exp   <= s2_exp + {11'd0, s2_carry};
            s3_iword <= s2_iword;
        end
    end

    // Saturating event counters, clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_ovf && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + CNT_W'(1);
            if (out_unf && !(&unf_cnt)) unf_cnt <= unf_cnt + CNT_W'(1);
        end
    end

endmodule
